// File: rtl/des_iter_core.sv
// Iterative DES core: ROUNDS_PER_CYCLE Feistel rounds per clock, optional CBC chaining.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never
// depends on ready, and a presented result holds until it is taken.
module des_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int CBC_EN           = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_decrypt,
    input  logic        in_cbc,
    input  logic        iv_load,
    input  logic [63:0] iv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
        $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    // Permutation tables use DES bit numbering: bit 1 is the MSB.
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    // S-boxes S1..S8, each 4 rows of 16 entries.
    localparam int SBOX [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    // Round function: expand, mix subkey, substitute, permute.
    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        int          v;
        x = '0;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            v = SBOX[b*64 + 32*int'(six[5]) + 16*int'(six[0]) + int'(six[4:1])];
            s[31-4*b -: 4] = v[3:0];
        end
        p = '0;
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        dec_q, dec_d, cbc_q, cbc_d;
    logic [63:0] blk_q, blk_d, chain_q, chain_d, out_data_q, out_data_d;

    logic [27:0] c_w, d_w;
    logic [31:0] l_w, r_w, t_w;
    logic [4:0]  rnd_w;
    logic        one_w, last_w;
    logic [63:0] fp_w, result_w, chain_in_w, pre_ip_w;

    // Cascade of rounds for this cycle; key halves rotate before PC-2 in each round.
    always_comb begin
        c_w = c_q; d_w = d_q; l_w = l_q; r_w = r_q; t_w = '0;
        rnd_w = '0; one_w = 1'b0;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            rnd_w = {1'b0, cnt_q} + 5'(k + 1);
            one_w = (rnd_w == 5'd1) || (rnd_w == 5'd2) || (rnd_w == 5'd9) || (rnd_w == 5'd16);
            if (!dec_q) begin
                c_w = one_w ? {c_w[26:0], c_w[27]} : {c_w[25:0], c_w[27:26]};
                d_w = one_w ? {d_w[26:0], d_w[27]} : {d_w[25:0], d_w[27:26]};
            end else if (rnd_w != 5'd1) begin
                c_w = one_w ? {c_w[0], c_w[27:1]} : {c_w[1:0], c_w[27:2]};
                d_w = one_w ? {d_w[0], d_w[27:1]} : {d_w[1:0], d_w[27:2]};
            end
            t_w = l_w ^ f_func(r_w, pc2_perm({c_w, d_w}));
            l_w = r_w;
            r_w = t_w;
        end
        last_w   = (({1'b0, cnt_q} + 5'(ROUNDS_PER_CYCLE)) == 5'd16);
        fp_w     = fp_perm({r_w, l_w});
        result_w = (dec_q && cbc_q) ? (fp_w ^ chain_q) : fp_w;
        // A same-cycle iv_load takes effect for the block being accepted.
        chain_in_w = iv_load ? iv : chain_q;
        pre_ip_w   = (CBC_EN != 0 && !in_decrypt && in_cbc) ? (in_data ^ chain_in_w) : in_data;
    end

    // Next-state and register updates for IDLE -> RUN -> DONE.
    always_comb begin
        state_d = state_q; cnt_d = cnt_q; l_d = l_q; r_d = r_q; c_d = c_q; d_d = d_q;
        dec_d = dec_q; cbc_d = cbc_q; blk_d = blk_q; chain_d = chain_q; out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (CBC_EN != 0 && iv_load) chain_d = iv;
                if (in_valid) begin
                    state_d    = S_RUN;
                    cnt_d      = '0;
                    dec_d      = in_decrypt;
                    cbc_d      = (CBC_EN != 0) && in_cbc;
                    blk_d      = in_data;
                    {c_d, d_d} = pc1_perm(in_key);
                    {l_d, r_d} = ip_perm(pre_ip_w);
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 4'(ROUNDS_PER_CYCLE);
                l_d = l_w; r_d = r_w; c_d = c_w; d_d = d_w;
                if (last_w) begin
                    state_d    = S_DONE;
                    out_data_d = result_w;
                    if (CBC_EN != 0 && cbc_q) chain_d = dec_q ? blk_q : fp_w;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset; reset drops any in-flight block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE; cnt_q <= '0; l_q <= '0; r_q <= '0; c_q <= '0; d_q <= '0;
            dec_q <= 1'b0; cbc_q <= 1'b0; blk_q <= '0; chain_q <= '0; out_data_q <= '0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; l_q <= l_d; r_q <= r_d; c_q <= c_d; d_q <= d_d;
            dec_q <= dec_d; cbc_q <= cbc_d; blk_q <= blk_d; chain_q <= chain_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_des_iter_core.sv
// Bench for des_iter_core: three instances (1, 4, 16 rounds per cycle) exercised in turn.
module tb_des_iter_core;

    localparam int NU = 3;
    localparam int RPC [NU] = '{1, 4, 16};
    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] PT2 = 64'h84CB563386A179EA;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] WK  = 64'h0101010101010101;
    localparam logic [63:0] WCT = 64'h8CA64DE9C1B123A7;

    logic        clk = 1'b0;
    logic        rst [NU];
    logic        in_valid [NU];
    logic        in_ready [NU];
    logic [63:0] in_data [NU];
    logic [63:0] in_key [NU];
    logic        in_decrypt [NU];
    logic        in_cbc [NU];
    logic        iv_load [NU];
    logic [63:0] iv [NU];
    logic        out_valid [NU];
    logic        out_ready [NU];
    logic [63:0] out_data [NU];
    logic        busy [NU];
    logic [1:0]  dbg_state [NU];

    logic [63:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int u = 0;
    int cyc = 0;

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        des_iter_core #(.ROUNDS_PER_CYCLE(RPC[g]), .CBC_EN(1)) u_dut (
            .clk(clk), .rst(rst[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_data(in_data[g]), .in_key(in_key[g]), .in_decrypt(in_decrypt[g]),
            .in_cbc(in_cbc[g]), .iv_load(iv_load[g]), .iv(iv[g]), .out_valid(out_valid[g]),
            .out_ready(out_ready[g]), .out_data(out_data[g]), .busy(busy[g]),
            .dbg_state(dbg_state[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (rpc=%0d): observed %h expected %h", tag, RPC[u], obs, exp);
        end
    endtask

    // Pulse reset on the current unit and check the reset state.
    task automatic do_reset();
        @(negedge clk);
        rst[u] = 1'b1;
        @(negedge clk);
        rst[u] = 1'b0;
        chk("rst_in_ready", 64'(in_ready[u]), 64'd1);
        chk("rst_out_valid", 64'(out_valid[u]), 64'd0);
        chk("rst_busy", 64'(busy[u]), 64'd0);
        chk("rst_out_data", out_data[u], 64'd0);
        chk("rst_state", 64'(dbg_state[u]), 64'd0);
    endtask

    // Load the chain register alone, while idle.
    task automatic load_iv(input logic [63:0] v);
        @(negedge clk);
        iv_load[u] = 1'b1; iv[u] = v;
        @(negedge clk);
        iv_load[u] = 1'b0;
    endtask

    // Drive one block, scramble inputs after acceptance, then collect the result.
    task automatic run_block(input string tag, input logic [63:0] data, input logic [63:0] key,
                             input logic dec, input logic cbc, input logic ivld,
                             input logic [63:0] ivv, input logic [63:0] exp,
                             input int hold, input logic pulse_iv);
        int  lat;
        logic got;
        exp_q.push_back(exp);
        @(negedge clk);
        chk({tag, "_accept_ready"}, 64'(in_ready[u]), 64'd1);
        in_valid[u] = 1'b1; in_data[u] = data; in_key[u] = key; in_decrypt[u] = dec;
        in_cbc[u] = cbc; iv_load[u] = ivld; iv[u] = ivv; out_ready[u] = 1'b0;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0; iv_load[u] = 1'b0;
        in_data[u] = {$urandom, $urandom}; in_key[u] = {$urandom, $urandom};
        in_decrypt[u] = 1'($urandom_range(0, 1)); in_cbc[u] = 1'($urandom_range(0, 1));
        lat = 0; got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk({tag, "_run_busy"}, 64'(busy[u]), 64'd1);
                if (pulse_iv) begin iv_load[u] = 1'b1; iv[u] = 64'hFFFF_FFFF_FFFF_FFFF; end
            end
            if (out_valid[u]) got = 1'b1;
        end
        if (!got) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            void'(exp_q.pop_front());
            iv_load[u] = 1'b0;
        end else begin
            chk({tag, "_latency"}, 64'(lat), 64'(16 / RPC[u] + 1));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, 64'(out_valid[u]), 64'd1);
                chk({tag, "_hold_ready"}, 64'(in_ready[u]), 64'd0);
                chk({tag, "_hold_data"}, out_data[u], exp_q[0]);
            end
            chk({tag, "_data"}, out_data[u], exp_q.pop_front());
            out_ready[u] = 1'b1;
            @(negedge clk);
            out_ready[u] = 1'b0; iv_load[u] = 1'b0;
            chk({tag, "_after_valid"}, 64'(out_valid[u]), 64'd0);
        end
    endtask

    // Back-to-back ECB blocks with out_ready held high; checks block period.
    task automatic stream_two();
        int seen;
        int t0;
        int t1;
        exp_q.push_back(CT); exp_q.push_back(CT);
        @(negedge clk);
        in_valid[u] = 1'b1; in_data[u] = PT; in_key[u] = KEY; in_decrypt[u] = 1'b0;
        in_cbc[u] = 1'b0; out_ready[u] = 1'b1;
        seen = 0; t0 = 0; t1 = 0;
        for (int n = 0; n < 80 && seen < 2; n++) begin
            @(negedge clk);
            if (out_valid[u]) begin
                if (seen == 0) t0 = cyc; else t1 = cyc;
                seen++;
                if (seen == 2) in_valid[u] = 1'b0;
                chk("stream_data", out_data[u], exp_q.pop_front());
            end
        end
        chk("stream_count", 64'(seen), 64'd2);
        if (seen == 2) chk("stream_period", 64'(t1 - t0), 64'(16 / RPC[u] + 2));
        exp_q.delete();
        in_valid[u] = 1'b0;
        @(negedge clk);
        out_ready[u] = 1'b0;
    endtask

    // Abort a CBC block in RUN; reset also wins over in_valid and iv_load.
    task automatic abort_run();
        logic seen_valid;
        load_iv(64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        in_valid[u] = 1'b1; in_data[u] = PT; in_key[u] = KEY; in_decrypt[u] = 1'b0; in_cbc[u] = 1'b1;
        @(negedge clk);
        chk("abort_in_run", 64'(dbg_state[u]), 64'd1);
        rst[u] = 1'b1; in_valid[u] = 1'b1; iv_load[u] = 1'b1; iv[u] = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        rst[u] = 1'b0; in_valid[u] = 1'b0; iv_load[u] = 1'b0;
        chk("abort_in_ready", 64'(in_ready[u]), 64'd1);
        chk("abort_out_valid", 64'(out_valid[u]), 64'd0);
        chk("abort_state", 64'(dbg_state[u]), 64'd0);
        chk("abort_out_data", out_data[u], 64'd0);
        seen_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid[u]) seen_valid = 1'b1;
        end
        chk("abort_no_result", 64'(seen_valid), 64'd0);
        // chain must be zero: CBC encrypt without iv_load gives the plain ECB result
        run_block("abort_chain0", PT, KEY, 1'b0, 1'b1, 1'b0, 64'd0, CT, 0, 1'b0);
    endtask

    // Directed sequence, repeated for each unit
    initial begin
        for (int i = 0; i < NU; i++) begin
            rst[i] = 1'b1; in_valid[i] = 1'b0; in_data[i] = '0; in_key[i] = '0;
            in_decrypt[i] = 1'b0; in_cbc[i] = 1'b0; iv_load[i] = 1'b0; iv[i] = '0;
            out_ready[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NU; i++) rst[i] = 1'b0;

        for (int i = 0; i < NU; i++) begin
            u = i;
            do_reset();
            run_block("ecb_enc", PT, KEY, 1'b0, 1'b0, 1'b0, 64'd0, CT, 0, 1'b0);
            run_block("ecb_dec", CT, KEY, 1'b1, 1'b0, 1'b0, 64'd0, PT, 0, 1'b0);
            run_block("cbc_enc1", PT, KEY, 1'b0, 1'b1, 1'b1, 64'd0, CT, 0, 1'b1);
            run_block("cbc_enc2", PT2, KEY, 1'b0, 1'b1, 1'b0, 64'd0, CT, 5, 1'b0);
            run_block("cbc_dec1", CT, KEY, 1'b1, 1'b1, 1'b1, 64'd0, PT, 0, 1'b0);
            run_block("cbc_dec2", CT, KEY, 1'b1, 1'b1, 1'b0, 64'd0, PT2, 0, 1'b0);
            run_block("cbc_iv_same", PT ^ 64'hDEAD_BEEF_CAFE_F00D, KEY, 1'b0, 1'b1, 1'b1,
                      64'hDEAD_BEEF_CAFE_F00D, CT, 0, 1'b0);
            stream_two();
            abort_run();
            run_block("weak_enc1", 64'd0, WK, 1'b0, 1'b0, 1'b0, 64'd0, WCT, 0, 1'b0);
            run_block("weak_enc2", WCT, WK, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
